// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RISC-V control path: FSM states, opcodes,
// ALU operation classes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic       ADR_PC  = 1'b0;
  localparam logic       ADR_ALU = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format select; purely combinational so pipelined
// variants can reuse it in their decode stage.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [1:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_I;
    case (i_op)
      OP_SW:   o_imm_src = IMM_S;
      OP_BEQ:  o_imm_src = IMM_B;
      OP_JAL:  o_imm_src = IMM_J;
      default: o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle RISC-V datapath: sequences each
// instruction and drives every enable, mux select and the ALU op class.
module multicycle_main_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_op
);

  state_t r_state;
  state_t w_next_state;
  logic [1:0] w_imm_src;

  imm_src_decoder u_imm_src_decoder (
    .i_op      (op),
    .o_imm_src (w_imm_src)
  );

  assign imm_src = w_imm_src;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH:    w_next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = MEMADR;
          OP_R:         w_next_state = EXECR;
          OP_I:         w_next_state = EXECI;
          OP_BEQ:       w_next_state = BEQ;
          OP_JAL:       w_next_state = JAL;
          default:      w_next_state = FETCH;
        endcase
      end
      MEMADR:   w_next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  w_next_state = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    w_next_state = FETCH;
      MEMWRITE: w_next_state = mem_ready ? FETCH : MEMWRITE;
      EXECR:    w_next_state = ALUWB;
      EXECI:    w_next_state = ALUWB;
      ALUWB:    w_next_state = FETCH;
      BEQ:      w_next_state = FETCH;
      JAL:      w_next_state = ALUWB;
      default:  w_next_state = FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    reg_write  = 1'b0;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    case (r_state)
      FETCH: begin
        adr_src    = ADR_PC;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_op = 1'b0;
          default:                                  illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        adr_src    = ADR_ALU;
        result_src = RES_ALUOUT;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src    = ADR_ALU;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
      end
      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides whatever state is held: FETCH selects, no side effects.
    if (!rst_n) begin
      pc_write   = 1'b0;
      adr_src    = ADR_PC;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = RES_ALURESULT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_FOUR;
      reg_write  = 1'b0;
      alu_op     = ALUOP_ADD;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle vector table plus
// hand sequences for wait states, illegal opcodes and mid-instruction reset.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

  multicycle_main_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, reg_write, alu_op}
  localparam logic [12:0] E_F1  = 13'b1_0_0_1_10_00_10_0_00;
  localparam logic [12:0] E_F0  = 13'b0_0_0_0_10_00_10_0_00;
  localparam logic [12:0] E_D   = 13'b0_0_0_0_00_01_01_0_00;
  localparam logic [12:0] E_MA  = 13'b0_0_0_0_00_10_01_0_00;
  localparam logic [12:0] E_MR  = 13'b0_1_0_0_00_00_00_0_00;
  localparam logic [12:0] E_MWB = 13'b0_0_0_0_01_00_00_1_00;
  localparam logic [12:0] E_MW  = 13'b0_1_1_0_00_00_00_0_00;
  localparam logic [12:0] E_XR  = 13'b0_0_0_0_00_10_00_0_10;
  localparam logic [12:0] E_XI  = 13'b0_0_0_0_00_10_01_0_10;
  localparam logic [12:0] E_AWB = 13'b0_0_0_0_00_00_00_1_00;
  localparam logic [12:0] E_B1  = 13'b1_0_0_0_00_10_00_0_01;
  localparam logic [12:0] E_B0  = 13'b0_0_0_0_00_10_00_0_01;
  localparam logic [12:0] E_J   = 13'b1_0_0_0_00_01_10_0_00;

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        mr;
    logic [12:0] base;
    logic [1:0]  imm;
    logic        ill;
    string       nm;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   mw_cnt, rw_cnt, ill_cnt;
  logic [1:0] last_aluop;

  function automatic vec_t mk(input logic [6:0] o, input logic z, input logic m,
                              input logic [12:0] b, input logic [1:0] im, input string nm);
    vec_t v;
    v.op = o; v.zero = z; v.mr = m; v.base = b; v.imm = im; v.ill = 1'b0; v.nm = nm;
    return v;
  endfunction

  // Reference ALUControlUnit decode for the R-type subtract check.
  function automatic logic [3:0] alu_con(input logic [1:0] aop, input logic [2:0] f3,
                                         input logic f7b5, input logic opb5);
    case (aop)
      2'b00:   return 4'b0010;
      2'b01:   return 4'b0110;
      default: begin
        case (f3)
          3'b000:  return (f7b5 & opb5) ? 4'b0110 : 4'b0010;
          3'b010:  return 4'b0111;
          3'b110:  return 4'b0001;
          3'b111:  return 4'b0000;
          default: return 4'b0010;
        endcase
      end
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic cyc(input logic [6:0] o, input logic z, input logic m,
                     input logic [12:0] b, input logic [1:0] im, input logic il,
                     input string nm);
    logic [15:0] got;
    op = o; zero = z; mem_ready = m;
    @(negedge clk);
    got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, reg_write, alu_op, imm_src, illegal_op};
    last_aluop = alu_op;
    if (mem_write === 1'b1) mw_cnt++;
    if (reg_write === 1'b1) rw_cnt++;
    if (illegal_op === 1'b1) ill_cnt++;
    check(nm, got, {b, im, il});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // lw, 5 cycles
    tbl.push_back(mk(LW, 0, 1, E_F1,  2'b00, "lw_fetch"));
    tbl.push_back(mk(LW, 0, 1, E_D,   2'b00, "lw_decode"));
    tbl.push_back(mk(LW, 0, 1, E_MA,  2'b00, "lw_memadr"));
    tbl.push_back(mk(LW, 0, 1, E_MR,  2'b00, "lw_memread"));
    tbl.push_back(mk(LW, 0, 1, E_MWB, 2'b00, "lw_memwb"));
    // R-type; op changes after decode must not alter the sequence
    tbl.push_back(mk(RT, 0, 1, E_F1,  2'b00, "r_fetch"));
    tbl.push_back(mk(RT, 0, 1, E_D,   2'b00, "r_decode"));
    tbl.push_back(mk(LW, 0, 1, E_XR,  2'b00, "r_execr_opchg"));
    tbl.push_back(mk(BAD, 0, 1, E_AWB, 2'b00, "r_aluwb_opchg"));
    // I-type
    tbl.push_back(mk(IT, 1, 1, E_F1,  2'b00, "i_fetch"));
    tbl.push_back(mk(IT, 1, 1, E_D,   2'b00, "i_decode"));
    tbl.push_back(mk(IT, 1, 1, E_XI,  2'b00, "i_execi"));
    tbl.push_back(mk(IT, 1, 1, E_AWB, 2'b00, "i_aluwb"));
    // jal
    tbl.push_back(mk(JL, 0, 1, E_F1,  2'b11, "jal_fetch"));
    tbl.push_back(mk(JL, 0, 1, E_D,   2'b11, "jal_decode"));
    tbl.push_back(mk(JL, 0, 1, E_J,   2'b11, "jal_jal"));
    tbl.push_back(mk(JL, 0, 1, E_AWB, 2'b11, "jal_aluwb"));
    // beq taken / not taken
    tbl.push_back(mk(BQ, 1, 1, E_F1,  2'b10, "beqt_fetch"));
    tbl.push_back(mk(BQ, 1, 1, E_D,   2'b10, "beqt_decode"));
    tbl.push_back(mk(BQ, 1, 1, E_B1,  2'b10, "beqt_beq"));
    tbl.push_back(mk(BQ, 0, 1, E_F1,  2'b10, "beqn_fetch"));
    tbl.push_back(mk(BQ, 0, 1, E_D,   2'b10, "beqn_decode"));
    tbl.push_back(mk(BQ, 0, 1, E_B0,  2'b10, "beqn_beq"));
    // sw, no waits
    tbl.push_back(mk(SW, 0, 1, E_F1,  2'b01, "sw_fetch"));
    tbl.push_back(mk(SW, 0, 1, E_D,   2'b01, "sw_decode"));
    tbl.push_back(mk(SW, 0, 1, E_MA,  2'b01, "sw_memadr"));
    tbl.push_back(mk(SW, 0, 1, E_MW,  2'b01, "sw_memwrite"));

    rst_n = 1'b0; op = SW; zero = 1'b0; mem_ready = 1'b1;
    mw_cnt = 0; rw_cnt = 0; ill_cnt = 0;

    // Reset held across two edges with op = sw
    cyc(SW, 0, 1, E_F0, 2'b01, 1'b0, "reset_a");
    cyc(SW, 0, 1, E_F0, 2'b01, 1'b0, "reset_b");
    rst_n = 1'b1;
    cyc(SW, 0, 0, E_F0, 2'b01, 1'b0, "release_fetch_stall");
    cyc(SW, 0, 0, E_F0, 2'b01, 1'b0, "fetch_stall_2");

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].op, tbl[i].zero, tbl[i].mr, tbl[i].base, tbl[i].imm, tbl[i].ill, tbl[i].nm);

    // sw with two wait cycles in MEMWRITE
    mw_cnt = 0; rw_cnt = 0;
    cyc(SW, 0, 1, E_F1, 2'b01, 1'b0, "swW_fetch");
    cyc(SW, 0, 1, E_D,  2'b01, 1'b0, "swW_decode");
    cyc(SW, 0, 1, E_MA, 2'b01, 1'b0, "swW_memadr");
    cyc(SW, 0, 0, E_MW, 2'b01, 1'b0, "swW_wait1");
    cyc(SW, 0, 0, E_MW, 2'b01, 1'b0, "swW_wait2");
    cyc(SW, 0, 1, E_MW, 2'b01, 1'b0, "swW_done");
    cyc(SW, 0, 0, E_F0, 2'b01, 1'b0, "swW_back_fetch");
    check("swW_mem_write_cycles", 16'(mw_cnt), 16'd3);
    check("swW_reg_write_never", 16'(rw_cnt), 16'd0);

    // Illegal opcode: one pulse in DECODE, then straight to FETCH
    ill_cnt = 0; mw_cnt = 0; rw_cnt = 0;
    cyc(BAD, 0, 1, E_F1, 2'b00, 1'b0, "ill_fetch");
    cyc(BAD, 0, 1, E_D,  2'b00, 1'b1, "ill_decode");
    cyc(BAD, 0, 1, E_F1, 2'b00, 1'b0, "ill_next_fetch");
    check("ill_pulse_count", 16'(ill_cnt), 16'd1);
    check("ill_no_writes", 16'(mw_cnt + rw_cnt), 16'd0);

    // R-type sub through the ALUControlUnit model (f7 = 0100000, f3 = 000)
    cyc(RT, 0, 1, E_D,  2'b00, 1'b0, "rsub_decode");
    cyc(RT, 0, 1, E_XR, 2'b00, 1'b0, "rsub_execr");
    check("rsub_alu_con", {12'd0, alu_con(last_aluop, 3'b000, 1'b1, RT[5])}, 16'h0006);
    cyc(RT, 0, 1, E_AWB, 2'b00, 1'b0, "rsub_aluwb");

    // lw with two wait cycles in MEMREAD
    cyc(LW, 0, 1, E_F1,  2'b00, 1'b0, "lwW_fetch");
    cyc(LW, 0, 1, E_D,   2'b00, 1'b0, "lwW_decode");
    cyc(LW, 0, 1, E_MA,  2'b00, 1'b0, "lwW_memadr");
    cyc(LW, 0, 0, E_MR,  2'b00, 1'b0, "lwW_wait1");
    cyc(LW, 0, 0, E_MR,  2'b00, 1'b0, "lwW_wait2");
    cyc(LW, 0, 1, E_MR,  2'b00, 1'b0, "lwW_done");
    cyc(LW, 0, 1, E_MWB, 2'b00, 1'b0, "lwW_memwb");

    // Reset asserted while in MEMWRITE: the store is abandoned
    cyc(SW, 0, 1, E_F1, 2'b01, 1'b0, "rstm_fetch");
    cyc(SW, 0, 1, E_D,  2'b01, 1'b0, "rstm_decode");
    cyc(SW, 0, 1, E_MA, 2'b01, 1'b0, "rstm_memadr");
    rst_n = 1'b0;
    cyc(SW, 0, 0, E_F0, 2'b01, 1'b0, "rstm_in_memwrite");
    rst_n = 1'b1;
    cyc(SW, 0, 0, E_F0, 2'b01, 1'b0, "rstm_after_fetch");
    cyc(SW, 0, 1, E_F1, 2'b01, 1'b0, "rstm_fetch_go");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle RISC-V datapath; sits directly upstream of ALUControlUnit and drives its aluOp input.
- Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Generates all datapath enables and mux selects; stalls on a memory-ready handshake.

Parameters:
- none (opcode and state encodings fixed in shared package)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- op  in  7  instruction opcode, instr[6:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result
- mem_write  out  1  data memory write request
- ir_write  out  1  instruction register enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- reg_write  out  1  register file write enable
- alu_op  out  2  to ALUControlUnit: 00 = add, 01 = sub, 10 = funct-decoded; 11 never driven
- imm_src  out  2  00 = I (lw, I-ALU), 01 = S, 10 = B, 11 = J; 00 for other opcodes
- illegal_op  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Single state register; all outputs are combinational from state, op, zero and mem_ready.
- Reset: rst_n sampled low at a rising edge puts the state in FETCH. While rst_n = 0, pc_write, ir_write, mem_write, reg_write and illegal_op are forced to 0. Remaining outputs take the FETCH values. Reset mid-sequence abandons the instruction with no write issued.
- Unlisted outputs in each state are 0 / 00.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- FETCH: adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while !mem_ready; on mem_ready go to DECODE.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00.
  - lw/sw -> MEMADR; R -> EXECR; I -> EXECI; beq -> BEQ; jal -> JAL.
  - Any other opcode -> FETCH with illegal_op = 1 for that cycle.
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: adr_src = 1, result_src = 00. Wait for mem_ready, then -> MEMWB.
- MEMWB: result_src = 01, reg_write = 1 -> FETCH.
- MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1 held for every cycle in the state. Wait for mem_ready, then -> FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10 -> ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10 -> ALUWB.
- ALUWB: result_src = 00, reg_write = 1 -> FETCH.
- BEQ: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, pc_write = zero -> FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_write = 1 -> ALUWB.
- Latencies with mem_ready always 1:
  - lw 5 cycles
  - sw 4 cycles
  - R/I/jal 4 cycles
  - beq 3 cycles
  - each mem_ready-low cycle in a wait state adds 1.
- op is sampled only in DECODE, MEMADR and for imm_src. op changing in other states has no effect.
- At most one of reg_write and mem_write is high in any cycle.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL)
  - opcode constants
  - alu_op constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - mux select constants
- One combinational sub-module, imm_src_decoder (op -> imm_src), shared with later pipelined variants.

Test Plan:
- Reset check: rst_n = 0 for 2 edges with op = sw, then release -> state FETCH, mem_write = reg_write = 0 during reset; first cycle after release alu_src_b = 10, alu_op = 00.
- lw with mem_ready = 1: op = 0000011 -> 5 cycles. reg_write = 1 only in cycle 5 with result_src = 01. imm_src = 00, alu_op = 00 throughout.
- R-type into ALUControlUnit: op = 0110011, f7/f3 = 0100000/000 -> EXECR alu_op = 10; DUT + ALUControlUnit produce con = 0110. ALUWB reg_write = 1; total 4 cycles.
- beq both ways: op = 1100011, zero = 1 -> pc_write = 1 in BEQ, alu_op = 01, imm_src = 10. Repeat with zero = 0 -> pc_write = 0. Each takes 3 cycles.
- sw with 2 wait cycles: mem_ready low 2 cycles in MEMWRITE -> mem_write = 1 for 3 consecutive cycles, then FETCH; reg_write never high.
- Illegal opcode 1111111 -> illegal_op = 1 exactly in DECODE, next state FETCH, no enables asserted.
